// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and the round-constant table.
package aes_pkg;

  localparam int AES_NR     = 10;
  localparam int AES_NK     = 4;
  localparam int AES_WORD_W = 32;
  localparam int AES_KEY_W  = AES_NK * AES_WORD_W;
  localparam int AES_RK_W   = 128;
  localparam int AES_EXP_W  = (AES_NR + 1) * AES_RK_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } kx_state_e;

  // Rcon[r] for r = 1..10; powers of x in GF(2^8).
  function automatic logic [7:0] aes_rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Key-in / expanded-key-out bundle between the key source and the expander.
interface aes_key_expander_if import aes_pkg::*; ();

  logic                 key_valid;
  logic [AES_KEY_W-1:0] key_in;
  logic                 key_ready;
  logic [AES_EXP_W-1:0] expanded_key;
  logic                 expanded_valid;
  logic                 busy;

  modport master (
    output key_valid, key_in,
    input  key_ready, expanded_key, expanded_valid, busy
  );

  modport slave (
    input  key_valid, key_in,
    output key_ready, expanded_key, expanded_valid, busy
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: multiplicative inverse in GF(2^8)
// followed by the affine transform. Shared with the SubBytes stage.
module aes_sbox (
  input  logic [7:0] data,
  output logic [7:0] sub
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      else      acc = acc;
      sh = sh[7] ? ({sh[6:0], 1'b0} ^ 8'h1b) : {sh[6:0], 1'b0};
    end
    return acc;
  endfunction

  // Inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // Inverse then affine map b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  always_comb begin
    logic [7:0] inv;
    inv = gf_inv(data);
    sub = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key expansion: one round key per clock, result held
// with expanded_valid until the next key is accepted.
module aes_key_expander import aes_pkg::*; #(
  parameter int NR    = AES_NR,
  parameter int KEY_W = AES_KEY_W
) (
  input logic               clk,
  input logic               rst_n,
  aes_key_expander_if.slave kx
);

  if (NR != 10) begin : g_bad_nr
    $error("aes_key_expander supports only NR = 10");
  end
  if (KEY_W != 128) begin : g_bad_key_w
    $error("aes_key_expander supports only KEY_W = 128");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  kx_state_e            state_r, state_nxt_s;
  logic [3:0]           round_r;
  logic [AES_KEY_W-1:0] work_r;
  logic [AES_EXP_W-1:0] expanded_key_r;
  logic                 expanded_valid_r;
  logic                 key_ready_r, key_ready_nxt_s;
  logic                 busy_r, busy_nxt_s;

  logic                  accept_s;
  logic                  last_round_s;
  logic [3:0]            slot_idx_s;
  logic [AES_WORD_W-1:0] w0_s, w1_s, w2_s, w3_s, rot_s, subw_s, t_s;
  logic [AES_WORD_W-1:0] n0_s, n1_s, n2_s, n3_s;

  assign accept_s     = kx.key_valid && key_ready_r;
  assign last_round_s = (state_r == EXPAND) && (round_r == LAST_ROUND);
  assign slot_idx_s   = LAST_ROUND - round_r;

  assign {w0_s, w1_s, w2_s, w3_s} = work_r;
  assign rot_s = {w3_s[23:0], w3_s[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .data (rot_s[b*8 +: 8]),
      .sub  (subw_s[b*8 +: 8])
    );
  end

  assign t_s  = subw_s ^ {aes_rcon(round_r), 24'h000000};
  assign n0_s = w0_s ^ t_s;
  assign n1_s = w1_s ^ n0_s;
  assign n2_s = w2_s ^ n1_s;
  assign n3_s = w3_s ^ n2_s;

  // State register plus registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      key_ready_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      key_ready_r <= key_ready_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  // Next-state logic: accept from IDLE/DONE, leave EXPAND after slot 10.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = EXPAND;
        else          state_nxt_s = IDLE;
      end
      EXPAND: begin
        if (last_round_s) state_nxt_s = DONE;
        else              state_nxt_s = EXPAND;
      end
      DONE: begin
        if (accept_s) state_nxt_s = EXPAND;
        else          state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode on the next state so the registered flags track state_r.
  always_comb begin
    key_ready_nxt_s = 1'b1;
    busy_nxt_s      = 1'b0;
    case (state_nxt_s)
      IDLE:    begin key_ready_nxt_s = 1'b1; busy_nxt_s = 1'b0; end
      EXPAND:  begin key_ready_nxt_s = 1'b0; busy_nxt_s = 1'b1; end
      DONE:    begin key_ready_nxt_s = 1'b1; busy_nxt_s = 1'b0; end
      default: begin key_ready_nxt_s = 1'b1; busy_nxt_s = 1'b0; end
    endcase
  end

  // Datapath: load round 0 on accept, then write one round-key slot per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expanded_key_r   <= '0;
      expanded_valid_r <= 1'b0;
      work_r           <= '0;
      round_r          <= 4'd0;
    end else if (accept_s) begin
      expanded_key_r[AES_EXP_W-1 -: AES_RK_W] <= kx.key_in;
      work_r           <= kx.key_in;
      round_r          <= 4'd1;
      expanded_valid_r <= 1'b0;
    end else if (state_r == EXPAND) begin
      expanded_key_r[{slot_idx_s, 7'd0} +: AES_RK_W] <= {n0_s, n1_s, n2_s, n3_s};
      work_r           <= {n0_s, n1_s, n2_s, n3_s};
      round_r          <= last_round_s ? round_r : round_r + 4'd1;
      expanded_valid_r <= last_round_s;
    end
  end

  assign kx.key_ready      = key_ready_r;
  assign kx.busy           = busy_r;
  assign kx.expanded_key   = expanded_key_r;
  assign kx.expanded_valid = expanded_valid_r;

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander using FIPS-197 and all-zero vectors.
module tb_aes_key_expander;
  import aes_pkg::*;

  typedef struct {
    logic [127:0] r0;
    logic [127:0] r1;
    logic [127:0] r10;
  } exp_t;

  localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_Z   = 128'h0;
  localparam logic [127:0] Z_R1    = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_R10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb[$];

  aes_key_expander_if ifc ();

  aes_key_expander #(.NR(10), .KEY_W(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kx    (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [127:0] r0, input logic [127:0] r1, input logic [127:0] r10);
    exp_t e;
    e.r0 = r0; e.r1 = r1; e.r10 = r10;
    sb.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send_key(input logic [127:0] k, input bit hold);
    int n;
    ifc.key_valid = 1'b1;
    ifc.key_in    = k;
    n = 0;
    while (!ifc.key_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_vec("ready_before_accept", {127'b0, ifc.key_ready}, 128'd1);
    @(posedge clk); #1;
    if (!hold) ifc.key_valid = 1'b0;
  endtask

  // Counts edges from accept to expanded_valid and cycles with key_ready low.
  task automatic wait_done(input string tag);
    int n;
    int low;
    n   = 0;
    low = ifc.key_ready ? 0 : 1;
    while (!ifc.expanded_valid && n < 30) begin
      @(posedge clk); #1; n++;
      if (!ifc.key_ready) low++;
    end
    check_vec({tag, "_latency"}, 128'(n), 128'd10);
    check_vec({tag, "_ready_low_cycles"}, 128'(low), 128'd10);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_vec({tag, "_key_zero"}, {127'b0, |ifc.expanded_key}, 128'd0);
    check_vec({tag, "_valid"},    {127'b0, ifc.expanded_valid}, 128'd0);
    check_vec({tag, "_ready"},    {127'b0, ifc.key_ready}, 128'd1);
    check_vec({tag, "_busy"},     {127'b0, ifc.busy}, 128'd0);
  endtask

  // Monitor: on each rising expanded_valid pop the oldest expectation.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ifc.expanded_valid && !prev) begin
        check_vec("valid_has_expectation", {127'b0, (sb.size() != 0)}, 128'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_vec("round0",  ifc.expanded_key[1407:1280], e.r0);
          check_vec("round1",  ifc.expanded_key[1279:1152], e.r1);
          check_vec("round10", ifc.expanded_key[127:0],     e.r10);
        end
      end
      prev = ifc.expanded_valid;
    end
  end

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    ifc.key_valid = 1'b0;
    ifc.key_in    = '0;
    #12;
    check_reset_outputs("reset");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 A.1 key.
    push_exp(KEY_A1, A1_R1, A1_R10);
    send_key(KEY_A1, 1'b0);
    check_vec("busy_in_expand", {127'b0, ifc.busy}, 128'd1);
    wait_done("a1");

    // Different key held during EXPAND must be ignored.
    push_exp(KEY_A1, A1_R1, A1_R10);
    send_key(KEY_A1, 1'b1);
    ifc.key_in = 128'hffeeddccbbaa99887766554433221100;
    wait_done("held");
    ifc.key_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_vec("held_done_stable", ifc.expanded_key[127:0], A1_R10);

    // Back-to-back from DONE with the all-zero key.
    push_exp(KEY_Z, Z_R1, Z_R10);
    send_key(KEY_Z, 1'b0);
    check_vec("b2b_valid_drop", {127'b0, ifc.expanded_valid}, 128'd0);
    wait_done("zero");

    // Reset in the middle of an expansion, then A.1 again.
    send_key(128'h00112233445566778899aabbccddeeff, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    push_exp(KEY_A1, A1_R1, A1_R10);
    send_key(KEY_A1, 1'b0);
    wait_done("post_reset");

    repeat (3) @(posedge clk);
    #1;
    check_vec("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
